// File: rtl/game_pkg.sv
// Shared types for the snake game controller: FSM state encoding and display mode codes.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        OVER  = 3'd3,
        WIN   = 3'd4
    } state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_PLAY = 2'b01;
    localparam logic [1:0] MODE_OVER = 2'b10;
    localparam logic [1:0] MODE_WIN  = 2'b11;

endpackage

// File: rtl/game_mode_fsm_move_tick_gen.sv
// Programmable period strobe: counts while enabled, freezes on hold, restarts on clear.
module move_tick_gen #(
    parameter int TICK_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TICK_W-1:0] period,
    input  logic              enable,
    input  logic              hold,
    input  logic              clear,
    output logic              move_tick
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    logic [TICK_W-1:0] count;

    // A clear cycle that is also enabled counts as position 0 of the first period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            move_tick <= 1'b0;
        end else if (clear) begin
            count     <= enable ? ONE : '0;
            move_tick <= 1'b0;
        end else if (enable) begin
            if (count >= period - ONE) begin
                count     <= '0;
                move_tick <= 1'b1;
            end else begin
                count     <= count + ONE;
                move_tick <= 1'b0;
            end
        end else begin
            move_tick <= 1'b0;
            if (!hold) begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/game_mode_fsm.sv
// Snake game state controller: start/pause/over/win sequencing, difficulty level and move tick.
module game_mode_fsm
    import game_pkg::*;
#(
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 12,
    parameter int LEVEL_STEP  = 4,
    parameter int NUM_LEVELS  = 4,
    localparam int LEVEL_W    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    parameter int BASE_PERIOD = 25_000_000,
    parameter int PERIOD_DEC  = 5_000_000,
    parameter int MIN_PERIOD  = 5_000_000,
    parameter int TICK_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               collide,
    input  logic [SCORE_W-1:0] score,
    output logic [1:0]         mode,
    output logic               paused,
    output logic [LEVEL_W-1:0] level,
    output logic               clear_pulse,
    output logic               move_tick,
    output state_t             state_dbg
);

    localparam int MAX_LEVEL = NUM_LEVELS - 1;

    state_t             state;
    logic               armed;
    logic               start_prev, pause_prev;
    logic               start_evt, pause_evt;
    logic [31:0]        score_div;
    logic [LEVEL_W-1:0] level_calc;
    logic [31:0]        dec_total;
    logic [TICK_W-1:0]  period;
    logic               hit, win_hit, in_play, play_exit;

    // Armed stays low for the first clock after reset so a held button gives no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
            start_evt  <= 1'b0;
            pause_evt  <= 1'b0;
        end else begin
            armed      <= 1'b1;
            start_prev <= btn_start;
            pause_prev <= btn_pause;
            start_evt  <= armed & btn_start & ~start_prev;
            pause_evt  <= armed & btn_pause & ~pause_prev;
        end
    end

    assign score_div  = 32'(score) / 32'(LEVEL_STEP);
    assign level_calc = (score_div > 32'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : LEVEL_W'(score_div);

    // Floor is tested before subtracting so the period never wraps.
    assign dec_total = 32'(level) * 32'(PERIOD_DEC);
    assign period    = (dec_total + 32'(MIN_PERIOD) >= 32'(BASE_PERIOD))
                     ? TICK_W'(MIN_PERIOD) : TICK_W'(32'(BASE_PERIOD) - dec_total);

    // Score is stale during the clear cycle, so collide and win are ignored then.
    assign hit       = collide & ~clear_pulse;
    assign win_hit   = (32'(score) >= 32'(WIN_SCORE)) & ~clear_pulse;
    assign in_play   = (state == PLAY);
    assign play_exit = in_play & (hit | win_hit | pause_evt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode        <= MODE_IDLE;
            paused      <= 1'b0;
            level       <= '0;
            clear_pulse <= 1'b0;
        end else begin
            clear_pulse <= 1'b0;
            case (state)
                IDLE, OVER, WIN: begin
                    if (start_evt) begin
                        state       <= PLAY;
                        mode        <= MODE_PLAY;
                        clear_pulse <= 1'b1;
                        level       <= '0;
                    end
                end
                PLAY: begin
                    if (!clear_pulse) begin
                        level <= level_calc;
                    end
                    if (hit) begin
                        state <= OVER;
                        mode  <= MODE_OVER;
                    end else if (win_hit) begin
                        state <= WIN;
                        mode  <= MODE_WIN;
                    end else if (pause_evt) begin
                        state  <= PAUSE;
                        paused <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (pause_evt) begin
                        state  <= PLAY;
                        paused <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mode   <= MODE_IDLE;
                    paused <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

    // The counter is frozen on the edge that leaves PLAY so no tick lands outside PLAY.
    move_tick_gen #(
        .TICK_W(TICK_W)
    ) u_move_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .period   (period),
        .enable   (in_play & ~play_exit),
        .hold     ((state == PAUSE) | play_exit),
        .clear    (clear_pulse | (state == IDLE) | (state == OVER) | (state == WIN)),
        .move_tick(move_tick)
    );

endmodule

// File: tb/tb_game_mode_fsm.sv
// Directed bench for game_mode_fsm with a cycle-level behavioural model checked every cycle.
module tb_game_mode_fsm;
  import game_pkg::*;

  localparam int SCORE_W    = 4;
  localparam int WIN_SCORE  = 12;
  localparam int LEVEL_STEP = 4;
  localparam int NUM_LEVELS = 4;
  localparam int LEVEL_W    = 2;
  localparam int BASE_P     = 10;
  localparam int DEC_P      = 2;
  localparam int MIN_P      = 4;
  localparam int TICK_W     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_start = 1'b0;
  logic btn_pause = 1'b0;
  logic collide = 1'b0;
  logic [SCORE_W-1:0] score = '0;
  logic [1:0] mode;
  logic paused;
  logic [LEVEL_W-1:0] level;
  logic clear_pulse;
  logic move_tick;
  state_t state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  game_mode_fsm #(
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .LEVEL_STEP(LEVEL_STEP),
    .NUM_LEVELS(NUM_LEVELS), .BASE_PERIOD(BASE_P), .PERIOD_DEC(DEC_P),
    .MIN_PERIOD(MIN_P), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .collide(collide), .score(score), .mode(mode), .paused(paused),
    .level(level), .clear_pulse(clear_pulse), .move_tick(move_tick),
    .state_dbg(state_dbg)
  );

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 play, 2 pause, 3 over, 4 win
  int m_phase = 0;
  int m_level = 0;
  int m_acc = 0;
  bit m_clear = 1'b0;
  bit m_tick = 1'b0;
  bit hs[$];
  bit hp[$];

  task automatic model_step();
    bit ev_s, ev_p, clr, tk;
    int per, lv;
    // a press acts two edges after the first high sample, needing a low sample before it
    ev_s = (hs.size() == 2) && hs[1] && !hs[0];
    ev_p = (hp.size() == 2) && hp[1] && !hp[0];
    hs.push_back(btn_start);
    if (hs.size() > 2) void'(hs.pop_front());
    hp.push_back(btn_pause);
    if (hp.size() > 2) void'(hp.pop_front());
    per = BASE_P - m_level * DEC_P;
    if (per < MIN_P) per = MIN_P;
    clr = 1'b0;
    tk = 1'b0;
    case (m_phase)
      0, 3, 4: begin
        if (ev_s) begin
          m_phase = 1;
          clr = 1'b1;
          m_level = 0;
          m_acc = 0;
        end
      end
      1: begin
        lv = m_level;
        if (!m_clear) begin
          lv = int'(score) / LEVEL_STEP;
          if (lv > NUM_LEVELS - 1) lv = NUM_LEVELS - 1;
        end
        if (collide && !m_clear) m_phase = 3;
        else if (int'(score) >= WIN_SCORE && !m_clear) m_phase = 4;
        else if (ev_p) m_phase = 2;
        else if (m_acc >= per - 1) begin
          tk = 1'b1;
          m_acc = 0;
        end else m_acc++;
        m_level = lv;
      end
      2: if (ev_p) m_phase = 1;
      default: m_phase = 0;
    endcase
    m_clear = clr;
    m_tick = tk;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_level = 0;
      m_acc = 0;
      m_clear = 1'b0;
      m_tick = 1'b0;
      hs.delete();
      hp.delete();
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [1:0] e_mode;
    logic e_paused;
    e_mode = (m_phase == 0) ? 2'd0 : (m_phase == 3) ? 2'd2 : (m_phase == 4) ? 2'd3 : 2'd1;
    e_paused = (m_phase == 2);
    n_vec++;
    if (mode !== e_mode || paused !== e_paused || level !== LEVEL_W'(m_level) ||
        clear_pulse !== m_clear || move_tick !== m_tick) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t (got/exp) mode=%0d/%0d paused=%0b/%0b level=%0d/%0d clear=%0b/%0b tick=%0b/%0b",
               $time, mode, e_mode, paused, e_paused, level, m_level, clear_pulse, m_clear, move_tick, m_tick);
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input int max, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (move_tick !== 1'b1 && cycles < max);
    if (move_tick !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_tick: no move_tick within %0d cycles", cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cnt;
    #1 rst_n = 1'b0;
    cyc(3);
    check("reset_outputs", {mode, paused, level, clear_pulse, move_tick}, 0);
    rst_n = 1'b1;
    cyc(2);

    // start, first tick, held start button
    btn_start = 1'b1;
    cyc(1);
    check("start_not_yet", mode, 0);
    cyc(1);
    check("start_mode", mode, 1);
    check("start_clear", clear_pulse, 1);
    wait_tick(40, n);
    check("first_tick_latency", n, 10);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (clear_pulse) cnt++;
    end
    check("held_start_no_clear", cnt, 0);
    btn_start = 1'b0;
    cyc(2);

    // level ramp and tick spacing
    score = 4'd4;
    wait_tick(40, n);
    wait_tick(40, n);
    check("spacing_level1", n, 8);
    check("level1", level, 1);
    score = 4'd8;
    wait_tick(40, n);
    wait_tick(40, n);
    check("spacing_level2", n, 6);
    check("level2", level, 2);

    // pause freezes counter, resume continues from frozen count
    wait_tick(40, n);
    btn_pause = 1'b1;
    cyc(2);
    check("paused_flag", paused, 1);
    check("paused_mode", mode, 1);
    btn_pause = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (move_tick) cnt++;
    end
    check("no_tick_in_pause", cnt, 0);
    btn_pause = 1'b1;
    wait_tick(40, n);
    check("resume_tick", n, 7);
    btn_pause = 1'b0;
    cyc(1);

    // collide beats win in the same cycle
    collide = 1'b1;
    score = 4'd12;
    cyc(1);
    check("collide_over_win", mode, 2);
    collide = 1'b0;
    score = 4'd0;
    cyc(2);
    check("over_holds", mode, 2);
    btn_start = 1'b1;
    cyc(2);
    check("restart_mode", mode, 1);
    check("restart_clear", clear_pulse, 1);
    check("restart_level0", level, 0);
    btn_start = 1'b0;

    // win with clamped level, ignored inputs, stale score on restart
    score = 4'd15;
    cyc(1);
    check("win_masked_clear", mode, 1);
    cyc(1);
    check("win_mode", mode, 3);
    check("level_clamp", level, 3);
    collide = 1'b1;
    btn_pause = 1'b1;
    cyc(4);
    check("win_holds", mode, 3);
    check("win_not_paused", paused, 0);
    collide = 1'b0;
    btn_pause = 1'b0;
    score = 4'd12;
    btn_start = 1'b1;
    cyc(2);
    check("win_restart_clear", clear_pulse, 1);
    cyc(1);
    check("stale_score_masked", mode, 1);
    score = 4'd0;
    btn_start = 1'b0;
    wait_tick(40, n);
    check("restart_first_tick", n, 9);

    // asynchronous reset during a tick, held start at release
    btn_start = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {mode, paused, level, clear_pulse, move_tick}, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    check("held_start_after_reset", mode, 0);
    btn_start = 1'b0;
    cyc(2);
    btn_start = 1'b1;
    cyc(2);
    check("start_after_reset", mode, 1);
    btn_start = 1'b0;
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/game_mode_fsm.md
# game_mode_fsm

Clocked, parametrised game-state controller for the snake game. It replaces the combinational mode decoder. It sequences idle, play, pause, game-over and win from debounced buttons, a collision flag and the score. It also derives the difficulty level and generates the snake movement tick whose period shrinks as the level rises. It sits between the button debouncers, the snake/score datapath and the VGA/LED display logic.

## Interface
- SCORE_W, 4: score bus width
- WIN_SCORE, 12: score at or above which the game is won
- LEVEL_STEP, 4: score points per level
- NUM_LEVELS, 4: number of levels; LEVEL_W = max(1, clog2(NUM_LEVELS)) is derived
- BASE_PERIOD, 25_000_000: move-tick period in clocks at level 0
- PERIOD_DEC, 5_000_000: period reduction per level
- MIN_PERIOD, 5_000_000: floor on move-tick period (≥2)
- TICK_W, 25: move counter width, must hold BASE_PERIOD-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- btn_start  in  1  debounced, synchronised middle button (level)
- btn_pause  in  1  debounced, synchronised pause button (level)
- collide  in  1  snake hit wall/self this cycle
- score  in  SCORE_W  current score from datapath
- mode  out  2  00 idle, 01 play (incl. paused), 10 game over, 11 win
- paused  out  1  high only in PAUSE
- level  out  LEVEL_W  current difficulty level
- clear_pulse  out  1  one-cycle request to datapath to reset snake and score
- move_tick  out  1  one-cycle snake step strobe

## Operation
- Buttons are rising-edge detected internally (registered previous value); a held button produces one event.
- States: IDLE, PLAY, PAUSE, OVER, WIN.
- IDLE: start event -> PLAY, clear_pulse.
- PLAY:
  - collide -> OVER.
  - else score ≥ WIN_SCORE -> WIN.
  - else pause event -> PAUSE.
  - Start event ignored.
- PAUSE:
  - Pause event -> PLAY.
  - Start event ignored.
  - collide and score ignored.
- OVER / WIN: start event -> PLAY with clear_pulse; all other inputs ignored.
- Priority in PLAY when simultaneous: collide > win > pause.
- Win and collide checks are masked in the cycle clear_pulse is high, because score is still stale.
- Level: min(score / LEVEL_STEP, NUM_LEVELS-1), registered.
  - Updated only in PLAY, outside the clear cycle.
  - Forced to 0 with clear_pulse.
  - Held in PAUSE, OVER and WIN.
- Period: max(BASE_PERIOD − level·PERIOD_DEC, MIN_PERIOD), computed combinationally from the level register. No underflow is allowed: the floor is applied before subtraction wraps.
- Move counter:
  - Counts 0..period−1 only in PLAY; move_tick is high in the cycle the counter equals period−1, then the counter wraps to 0.
  - If the level rises and counter ≥ period−1, fire move_tick and wrap on that cycle.
  - Held in PAUSE; cleared to 0 on clear_pulse and in IDLE/OVER/WIN.
  - No tick outside PLAY.

## Timing
- Reset values: state IDLE, mode 00, paused 0, level 0, clear_pulse 0, move_tick 0, move counter 0, button edge registers 0.
- All outputs are registered.
- Button edge to state/mode change: 1 cycle after the first clock at which the button is sampled high. Example: btn_start rises before edge N, so mode is 01 and clear_pulse is 1 after edge N+1.
- clear_pulse is exactly one cycle wide and coincides with the first PLAY cycle.
- collide or score threshold to mode change: registered on the next edge, 1-cycle latency.
- First move_tick after start: `period` cycles after the clear_pulse cycle.
- Reset asserted mid-game: immediate return to reset values. A button still held at reset release produces no event, because edge registers reload from the input on the first clock after release.

## Structure
- Shared package game_pkg:
  - state typedef (IDLE, PLAY, PAUSE, OVER, WIN).
  - mode constants MODE_IDLE=2'b00, MODE_PLAY=2'b01, MODE_OVER=2'b10, MODE_WIN=2'b11.
- One sub-module: move_tick_gen.
  - Inputs: period, enable, hold, clear.
  - Output: move_tick.
  - Reused by the future food-blink timer.
- The FSM, edge detectors and level logic stay in the top.

## Test plan
Sim params: BASE_PERIOD=10, PERIOD_DEC=2, MIN_PERIOD=4, TICK_W=4, WIN_SCORE=12, LEVEL_STEP=4.
- Reset, then pulse btn_start -> mode 00 to 01; one clear_pulse; first move_tick 10 cycles later; holding btn_start 50 cycles gives no second clear_pulse.
- In PLAY, ramp score 0,4,8 -> level 0,1,2; tick spacing 10, 8, 6 clocks; score 15 with NUM_LEVELS=4 gives level 3 and period 4, never below MIN_PERIOD.
- In PLAY, press pause -> paused=1, mode stays 01, no move_tick, counter frozen; press again -> ticks resume from the frozen count.
- collide and score=12 in the same cycle -> mode 10, not 11; then btn_start -> mode 01 with clear_pulse and level 0.
- score reaches 12 -> mode 11; collide and pause afterwards ignored; btn_start restarts, and a stale score=12 during the clear cycle does not re-trigger WIN.
- Assert rst_n low mid-PLAY during a move_tick -> all outputs 0 immediately; release with btn_start held -> stays in IDLE.
